// File: rtl/fact_game_pkg.sv
// Shared types and tables for the factorization game controller.
// The state codes are the values expected by the 7-segment decoder.
package fact_game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Button code to prime value; 0 marks an invalid code.
  function automatic logic [2:0] prime_val(input logic [3:0] code);
    case (code)
      4'd1:    prime_val = 3'd2;
      4'd2:    prime_val = 3'd3;
      4'd3:    prime_val = 3'd5;
      4'd4:    prime_val = 3'd7;
      default: prime_val = 3'd0;
    endcase
  endfunction

  // Every entry is 7-smooth and below 100 so it fits two decimal digits.
  function automatic logic [6:0] question_val(input logic [3:0] idx);
    case (idx)
      4'd0:    question_val = 7'd12;
      4'd1:    question_val = 7'd18;
      4'd2:    question_val = 7'd20;
      4'd3:    question_val = 7'd28;
      4'd4:    question_val = 7'd30;
      4'd5:    question_val = 7'd42;
      4'd6:    question_val = 7'd45;
      4'd7:    question_val = 7'd49;
      4'd8:    question_val = 7'd50;
      4'd9:    question_val = 7'd56;
      4'd10:   question_val = 7'd63;
      4'd11:   question_val = 7'd70;
      4'd12:   question_val = 7'd75;
      4'd13:   question_val = 7'd84;
      4'd14:   question_val = 7'd90;
      4'd15:   question_val = 7'd98;
      default: question_val = 7'd12;
    endcase
  endfunction

endpackage

// File: rtl/fact_question_rom.sv
// Question lookup: 4-bit index to question value and its decimal digits.
module fact_question_rom
  import fact_game_pkg::*;
(
  input  logic [3:0] idx,
  output logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Table lookup and decimal split; values stay below 100.
  always_comb begin
    value = question_val(idx);
    tens  = 4'(value / 7'd10);
    ones  = 4'(value % 7'd10);
  end

endmodule

// File: rtl/fact_game_ctrl.sv
// Main FSM of the factorization game: phase timing, question selection, prime judging, scoring.
// Optional macro FACT_RANDOM_Q_EN selects questions from an LFSR instead of a sequential counter.
module fact_game_ctrl
  import fact_game_pkg::*;
#(
  parameter int READY_CYC   = 50_000_000,
  parameter int QDIG_CYC    = 50_000_000,
  parameter int RESULT_CYC  = 100_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int NROUND      = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       START,
  input  logic       BTN_VALID,
  input  logic [3:0] BTN_PRIME,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] DIN,
  output logic [3:0] SCORE
);

  localparam int MAX_AB = (READY_CYC > QDIG_CYC) ? READY_CYC : QDIG_CYC;
  localparam int MAX_CD = (RESULT_CYC > TIMEOUT_CYC) ? RESULT_CYC : TIMEOUT_CYC;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Loading N-1 and leaving on zero makes each phase last exactly N cycles.
  localparam logic [CW-1:0] LD_READY   = CW'(READY_CYC - 1);
  localparam logic [CW-1:0] LD_QDIG    = CW'(QDIG_CYC - 1);
  localparam logic [CW-1:0] LD_RESULT  = CW'(RESULT_CYC - 1);
  localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    NR         = 4'(NROUND);
  localparam logic [4:0]    NR2        = 5'(NROUND);

  state_e        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [6:0]    rem_r, rem_s;
  logic [3:0]    que_r, que_s;
  logic [3:0]    din_r, din_s;
  logic [3:0]    score_r, score_s;
  logic [3:0]    round_r, round_s;
  logic          digit_r, digit_s;
  logic          adv_idx_s;
  logic [3:0]    q_idx_s;
  logic [6:0]    q_value_s;
  logic [3:0]    q_tens_s, q_ones_s;
  logic [2:0]    pval_s;
  logic [6:0]    quot_s;
  logic          divisible_s;
  logic [3:0]    round_inc_s;
  state_e        verdict_s;

  fact_question_rom u_rom (
    .idx   (q_idx_s),
    .value (q_value_s),
    .tens  (q_tens_s),
    .ones  (q_ones_s)
  );

`ifdef FACT_RANDOM_Q_EN
  logic [7:0] lfsr_r;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) lfsr_r <= LFSR_SEED;
    else       lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  assign q_idx_s = lfsr_r[3:0];
`else
  logic [3:0] seq_r;

  // Sequential question index; only a hardware reset rewinds it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          seq_r <= 4'd0;
    else if (adv_idx_s) seq_r <= seq_r + 4'd1;
    else                seq_r <= seq_r;
  end

  assign q_idx_s = seq_r;
`endif

  // Constant-divisor quotient and divisibility of the remaining value.
  always_comb begin
    pval_s      = prime_val(BTN_PRIME);
    quot_s      = rem_r;
    divisible_s = 1'b0;
    case (pval_s)
      3'd2: begin quot_s = rem_r >> 1;    divisible_s = (rem_r[0] == 1'b0);       end
      3'd3: begin quot_s = rem_r / 7'd3;  divisible_s = ((rem_r % 7'd3) == 7'd0); end
      3'd5: begin quot_s = rem_r / 7'd5;  divisible_s = ((rem_r % 7'd5) == 7'd0); end
      3'd7: begin quot_s = rem_r / 7'd7;  divisible_s = ((rem_r % 7'd7) == 7'd0); end
      default: begin quot_s = rem_r; divisible_s = 1'b0; end
    endcase
  end

  // Game verdict from the score against the round count.
  always_comb begin
    round_inc_s = round_r + 4'd1;
    if ({score_r, 1'b0} > NR2)       verdict_s = ST_WIN;
    else if ({score_r, 1'b0} == NR2) verdict_s = ST_DRAW;
    else                             verdict_s = ST_LOSE;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rem_s     = rem_r;
    que_s     = que_r;
    din_s     = din_r;
    score_s   = score_r;
    round_s   = round_r;
    digit_s   = digit_r;
    adv_idx_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_WIN, ST_LOSE, ST_DRAW: begin
        if (START) begin
          state_s = ST_READY;
          cnt_s   = LD_READY;
          score_s = 4'd0;
          round_s = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_READY: begin
        if (cnt_r == CNT_ZERO) begin
          state_s   = ST_QUESTION;
          cnt_s     = LD_QDIG;
          rem_s     = q_value_s;
          que_s     = q_tens_s;
          digit_s   = 1'b0;
          adv_idx_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_QUESTION: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (!digit_r) begin
          digit_s = 1'b1;
          que_s   = 4'(rem_r % 7'd10);
          cnt_s   = LD_QDIG;
        end else begin
          state_s = ST_INPUT;
          din_s   = 4'd0;
          cnt_s   = LD_TIMEOUT;
        end
      end
      ST_INPUT: begin
        // A press on the expiry cycle takes priority over the timeout.
        if (BTN_VALID) begin
          din_s = BTN_PRIME;
          if (divisible_s) begin
            rem_s = quot_s;
            if (quot_s == 7'd1) begin
              state_s = ST_GOOD;
              score_s = score_r + 4'd1;
              cnt_s   = LD_RESULT;
            end else begin
              cnt_s = LD_TIMEOUT;
            end
          end else begin
            state_s = ST_WRONG;
            cnt_s   = LD_RESULT;
          end
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_OUCH;
          cnt_s   = LD_RESULT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GOOD, ST_WRONG, ST_OUCH: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (round_inc_s == NR) begin
          round_s = round_inc_s;
          state_s = verdict_s;
        end else begin
          round_s = round_inc_s;
          state_s = ST_READY;
          cnt_s   = LD_READY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      rem_r   <= 7'd0;
      que_r   <= 4'd0;
      din_r   <= 4'd0;
      score_r <= 4'd0;
      round_r <= 4'd0;
      digit_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      que_r   <= que_s;
      din_r   <= din_s;
      score_r <= score_s;
      round_r <= round_s;
      digit_r <= digit_s;
    end
  end

  assign STATE = state_r;
  assign QUE   = que_r;
  assign DIN   = din_r;
  assign SCORE = score_r;

endmodule

// File: tb/tb_fact_game_ctrl.sv
// Self-checking bench for fact_game_ctrl with short phase timings; a second
// instance with two rounds per game covers the DRAW verdict.
module tb_fact_game_ctrl;

  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_READY = 4'b0010;
  localparam logic [3:0] S_QUES  = 4'b0011;
  localparam logic [3:0] S_INPUT = 4'b0100;
  localparam logic [3:0] S_DRAW  = 4'b0110;
  localparam logic [3:0] S_WRONG = 4'b0111;
  localparam logic [3:0] S_GOOD  = 4'b1000;
  localparam logic [3:0] S_OUCH  = 4'b1001;
  localparam logic [3:0] S_WIN   = 4'b1010;
  localparam logic [3:0] S_LOSE  = 4'b1011;

  typedef struct {
    logic       start;
    logic       bv;
    logic [3:0] bp;
    int         rep;
    logic [3:0] st;
    logic [3:0] que;
    logic [3:0] din;
    logic [3:0] score;
  } vec_t;

  logic CLK, nRST, start, bv, sel;
  logic [3:0] bp;
  logic [3:0] state1, que1, din1, score1;
  logic [3:0] state2, que2, din2, score2;
  logic [3:0] state_m, que_m, din_m, score_m;
  int checks, errors;
  vec_t vecs[$];

  fact_game_ctrl #(.READY_CYC(4), .QDIG_CYC(4), .RESULT_CYC(4), .TIMEOUT_CYC(20), .NROUND(3)) dut (
    .CLK(CLK), .nRST(nRST), .START(start & ~sel), .BTN_VALID(bv & ~sel), .BTN_PRIME(sel ? 4'd0 : bp),
    .STATE(state1), .QUE(que1), .DIN(din1), .SCORE(score1));

  fact_game_ctrl #(.READY_CYC(4), .QDIG_CYC(4), .RESULT_CYC(4), .TIMEOUT_CYC(20), .NROUND(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .START(start & sel), .BTN_VALID(bv & sel), .BTN_PRIME(sel ? bp : 4'd0),
    .STATE(state2), .QUE(que2), .DIN(din2), .SCORE(score2));

  assign state_m = sel ? state2 : state1;
  assign que_m   = sel ? que2   : que1;
  assign din_m   = sel ? din2   : din1;
  assign score_m = sel ? score2 : score1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input logic [3:0] st, input logic [3:0] q,
                     input logic [3:0] d, input logic [3:0] sc);
    chk1(nm, "STATE", state_m, st);
    chk1(nm, "QUE",   que_m,   q);
    chk1(nm, "DIN",   din_m,   d);
    chk1(nm, "SCORE", score_m, sc);
  endtask

  task automatic step(input logic s, input logic b, input logic [3:0] p);
    start = s; bv = b; bp = p;
    @(posedge CLK); #1;
    start = 1'b0; bv = 1'b0; bp = 4'd0;
  endtask

  task automatic act(input string nm, input logic s, input logic b, input logic [3:0] p,
                     input logic [3:0] st, input logic [3:0] q, input logic [3:0] d, input logic [3:0] sc);
    step(s, b, p);
    cmp(nm, st, q, d, sc);
  endtask

  task automatic run(input string nm, input int n, input logic [3:0] st, input logic [3:0] q,
                     input logic [3:0] d, input logic [3:0] sc);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 4'd0);
      cmp($sformatf("%s[%0d]", nm, k), st, q, d, sc);
    end
  endtask

  task automatic add(input logic s, input logic b, input logic [3:0] p, input int rep,
                     input logic [3:0] st, input logic [3:0] q, input logic [3:0] d, input logic [3:0] sc);
    vec_t v;
    v.start = s; v.bv = b; v.bp = p; v.rep = rep;
    v.st = st; v.que = q; v.din = d; v.score = sc;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    nRST = 1'b0; start = 1'b0; bv = 1'b0; bp = 4'd0; sel = 1'b0;

    // Game 1: Q=12 solved, Q=18 wrong prime, Q=20 invalid code 0 -> LOSE
    add(1,0,4'd0,1,S_READY,4'd0,4'd0,4'd0);
    add(0,0,4'd0,3,S_READY,4'd0,4'd0,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd1,4'd0,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd2,4'd0,4'd0);
    add(0,0,4'd0,1,S_INPUT,4'd2,4'd0,4'd0);
    add(0,1,4'd1,1,S_INPUT,4'd2,4'd1,4'd0);
    add(0,0,4'd0,2,S_INPUT,4'd2,4'd1,4'd0);
    add(0,1,4'd1,1,S_INPUT,4'd2,4'd1,4'd0);
    add(0,1,4'd2,1,S_GOOD, 4'd2,4'd2,4'd1);
    add(0,0,4'd0,3,S_GOOD, 4'd2,4'd2,4'd1);
    add(0,0,4'd0,4,S_READY,4'd2,4'd2,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd1,4'd2,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd8,4'd2,4'd1);
    add(0,0,4'd0,1,S_INPUT,4'd8,4'd0,4'd1);
    add(0,1,4'd3,1,S_WRONG,4'd8,4'd3,4'd1);
    add(0,0,4'd0,3,S_WRONG,4'd8,4'd3,4'd1);
    add(0,0,4'd0,4,S_READY,4'd8,4'd3,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd2,4'd3,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd0,4'd3,4'd1);
    add(0,0,4'd0,1,S_INPUT,4'd0,4'd0,4'd1);
    add(0,1,4'd0,1,S_WRONG,4'd0,4'd0,4'd1);
    add(0,0,4'd0,3,S_WRONG,4'd0,4'd0,4'd1);
    add(0,0,4'd0,3,S_LOSE, 4'd0,4'd0,4'd1);
    // Game 2: START/BTN in READY ignored; Q=28 code 9, Q=30 and Q=42 solved -> WIN
    add(1,0,4'd0,1,S_READY,4'd0,4'd0,4'd0);
    add(1,0,4'd0,1,S_READY,4'd0,4'd0,4'd0);
    add(0,1,4'd1,1,S_READY,4'd0,4'd0,4'd0);
    add(0,0,4'd0,1,S_READY,4'd0,4'd0,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd2,4'd0,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd8,4'd0,4'd0);
    add(0,0,4'd0,1,S_INPUT,4'd8,4'd0,4'd0);
    add(0,1,4'd9,1,S_WRONG,4'd8,4'd9,4'd0);
    add(0,0,4'd0,3,S_WRONG,4'd8,4'd9,4'd0);
    add(0,0,4'd0,4,S_READY,4'd8,4'd9,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd3,4'd9,4'd0);
    add(0,0,4'd0,4,S_QUES, 4'd0,4'd9,4'd0);
    add(0,0,4'd0,1,S_INPUT,4'd0,4'd0,4'd0);
    add(0,1,4'd1,1,S_INPUT,4'd0,4'd1,4'd0);
    add(0,1,4'd2,1,S_INPUT,4'd0,4'd2,4'd0);
    add(0,1,4'd3,1,S_GOOD, 4'd0,4'd3,4'd1);
    add(0,0,4'd0,3,S_GOOD, 4'd0,4'd3,4'd1);
    add(0,0,4'd0,4,S_READY,4'd0,4'd3,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd4,4'd3,4'd1);
    add(0,0,4'd0,4,S_QUES, 4'd2,4'd3,4'd1);
    add(0,0,4'd0,1,S_INPUT,4'd2,4'd0,4'd1);
    add(0,1,4'd1,1,S_INPUT,4'd2,4'd1,4'd1);
    add(0,1,4'd2,1,S_INPUT,4'd2,4'd2,4'd1);
    add(0,1,4'd4,1,S_GOOD, 4'd2,4'd4,4'd2);
    add(0,0,4'd0,3,S_GOOD, 4'd2,4'd4,4'd2);
    add(0,0,4'd0,2,S_WIN,  4'd2,4'd4,4'd2);
    add(0,1,4'd1,1,S_WIN,  4'd2,4'd4,4'd2);

    #1;
    cmp("reset", S_IDLE, 4'd0, 4'd0, 4'd0);
    @(negedge CLK);
    nRST = 1'b1;
    act("idle_no_start", 1'b0, 1'b0, 4'd0, S_IDLE, 4'd0, 4'd0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        if (r == 0) step(vecs[i].start, vecs[i].bv, vecs[i].bp);
        else        step(1'b0, 1'b0, 4'd0);
        cmp($sformatf("vec%0d.%0d", i, r), vecs[i].st, vecs[i].que, vecs[i].din, vecs[i].score);
      end
    end

    // Game 3, Q=45: timeout after exactly 20 idle INPUT cycles
    act("g3_start", 1'b1, 1'b0, 4'd0, S_READY, 4'd2, 4'd4, 4'd0);
    run("g3_ready", 3, S_READY, 4'd2, 4'd4, 4'd0);
    run("g3_q45_t", 4, S_QUES, 4'd4, 4'd4, 4'd0);
    run("g3_q45_o", 4, S_QUES, 4'd5, 4'd4, 4'd0);
    run("timeout_wait", 20, S_INPUT, 4'd5, 4'd0, 4'd0);
    act("timeout_ouch", 1'b0, 1'b0, 4'd0, S_OUCH, 4'd5, 4'd0, 4'd0);
    run("ouch_hold", 3, S_OUCH, 4'd5, 4'd0, 4'd0);
    run("g3_ready2", 4, S_READY, 4'd5, 4'd0, 4'd0);
    // Q=49: second 7 pressed on the cycle the restarted timeout expires
    run("g3_q49_t", 4, S_QUES, 4'd4, 4'd0, 4'd0);
    run("g3_q49_o", 4, S_QUES, 4'd9, 4'd0, 4'd0);
    run("g3_in49", 1, S_INPUT, 4'd9, 4'd0, 4'd0);
    act("press7_a", 1'b0, 1'b1, 4'd4, S_INPUT, 4'd9, 4'd4, 4'd0);
    run("restart_wait", 19, S_INPUT, 4'd9, 4'd4, 4'd0);
    act("press_on_expiry", 1'b0, 1'b1, 4'd4, S_GOOD, 4'd9, 4'd4, 4'd1);
    run("good_hold", 3, S_GOOD, 4'd9, 4'd4, 4'd1);
    run("g3_ready3", 4, S_READY, 4'd9, 4'd4, 4'd1);
    // Q=50: asynchronous reset in the middle of INPUT
    run("g3_q50_t", 4, S_QUES, 4'd5, 4'd4, 4'd1);
    run("g3_q50_o", 4, S_QUES, 4'd0, 4'd4, 4'd1);
    run("g3_in50", 1, S_INPUT, 4'd0, 4'd0, 4'd1);
    act("press2_50", 1'b0, 1'b1, 4'd1, S_INPUT, 4'd0, 4'd1, 4'd1);
    #2;
    nRST = 1'b0;
    #1;
    cmp("async_reset", S_IDLE, 4'd0, 4'd0, 4'd0);
    act("start_in_reset", 1'b1, 1'b0, 4'd0, S_IDLE, 4'd0, 4'd0, 4'd0);
    #2;
    nRST = 1'b1;
    act("after_reset", 1'b0, 1'b0, 4'd0, S_IDLE, 4'd0, 4'd0, 4'd0);

    // Two-round instance: one solved, one wrong -> DRAW, then restart
    sel = 1'b1;
    act("d_start", 1'b1, 1'b0, 4'd0, S_READY, 4'd0, 4'd0, 4'd0);
    run("d_ready", 3, S_READY, 4'd0, 4'd0, 4'd0);
    run("d_q12_t", 4, S_QUES, 4'd1, 4'd0, 4'd0);
    run("d_q12_o", 4, S_QUES, 4'd2, 4'd0, 4'd0);
    run("d_in12", 1, S_INPUT, 4'd2, 4'd0, 4'd0);
    act("d_p1", 1'b0, 1'b1, 4'd1, S_INPUT, 4'd2, 4'd1, 4'd0);
    act("d_p2", 1'b0, 1'b1, 4'd1, S_INPUT, 4'd2, 4'd1, 4'd0);
    act("d_p3", 1'b0, 1'b1, 4'd2, S_GOOD, 4'd2, 4'd2, 4'd1);
    run("d_good", 3, S_GOOD, 4'd2, 4'd2, 4'd1);
    run("d_ready2", 4, S_READY, 4'd2, 4'd2, 4'd1);
    run("d_q18_t", 4, S_QUES, 4'd1, 4'd2, 4'd1);
    run("d_q18_o", 4, S_QUES, 4'd8, 4'd2, 4'd1);
    run("d_in18", 1, S_INPUT, 4'd8, 4'd0, 4'd1);
    act("d_code0", 1'b0, 1'b1, 4'd0, S_WRONG, 4'd8, 4'd0, 4'd1);
    run("d_wrong", 3, S_WRONG, 4'd8, 4'd0, 4'd1);
    run("draw", 2, S_DRAW, 4'd8, 4'd0, 4'd1);
    act("restart_draw", 1'b1, 1'b0, 4'd0, S_READY, 4'd8, 4'd0, 4'd0);
    run("d_ready3", 3, S_READY, 4'd8, 4'd0, 4'd0);
    run("d_q20_t", 1, S_QUES, 4'd2, 4'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
